// File: rtl/skolem_sweep_checker_if.sv
// Request/acknowledge channel between the sweep checker (master) and the
// candidate Skolem function under test (slave).
interface skolem_sweep_checker_if;
  logic [5:0] cand_x;
  logic       cand_req;
  logic       cand_ack;
  logic       cand_y;

  modport master (output cand_x, output cand_req, input cand_ack, input cand_y);
  modport slave  (input cand_x, input cand_req, output cand_ack, output cand_y);
endinterface

// File: rtl/skolem_sweep_checker.sv
// Sweeps all 64 universal-input vectors through a candidate Skolem function and
// checks each response against the relation F(x, y) held in SPEC_TT.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   REQ   | cand_x driven, waiting for cand_ack (bounded by TIMEOUT)
//   CHECK | evaluate latched response against SPEC_TT
//   DONE  | results valid and held until the next start
module skolem_sweep_checker #(
  parameter logic [127:0] SPEC_TT      = 128'h0,
  parameter int           TIMEOUT      = 16,
  parameter bit           STOP_ON_FAIL = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  skolem_sweep_checker_if.master        cand,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [5:0]                    cex_x,
  output logic [6:0]                    n_fail,
  output logic [6:0]                    n_vac
);

  localparam int           WW     = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_TC = WW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CHECK, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [5:0]    x_q, x_d;
  logic          y_q, y_d;
  logic [WW-1:0] wait_q, wait_d, wait_inc;
  logic [6:0]    n_fail_q, n_fail_d;
  logic [6:0]    n_vac_q, n_vac_d;
  logic [5:0]    cex_x_q, cex_x_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;
  logic          cand_req_q, cand_req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ok, sat, fail;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    wait_d     = wait_q;
    n_fail_d   = n_fail_q;
    n_vac_d    = n_vac_q;
    cex_x_d    = cex_x_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    wait_inc   = wait_q + 1'b1;
    ok         = SPEC_TT[{y_q, x_q}];
    sat        = SPEC_TT[{1'b0, x_q}] | SPEC_TT[{1'b1, x_q}];
    fail       = sat & ~ok;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          x_d       = '0;
          n_fail_d  = '0;
          n_vac_d   = '0;
          cex_x_d   = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          wait_d    = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (cand.cand_ack) begin
          y_d     = cand.cand_y;
          state_d = S_CHECK;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_TC) begin
            timeout_d = 1'b1;
            pass_d    = 1'b0;
            state_d   = S_DONE;
          end
        end
      end
      S_CHECK: begin
        // A vacuous vector (no y satisfies F) can never be a failure.
        if (!sat) n_vac_d = n_vac_q + 7'd1;
        if (fail) begin
          n_fail_d = n_fail_q + 7'd1;
          if (n_fail_q == 7'd0) cex_x_d = x_q;
        end
        if ((fail && STOP_ON_FAIL) || (x_q == 6'd63)) begin
          pass_d  = (n_fail_d == 7'd0) & ~timeout_q;
          state_d = S_DONE;
        end else begin
          x_d     = x_q + 6'd1;
          wait_d  = '0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cand_req_d = (state_d == S_REQ);
    busy_d     = (state_d == S_REQ) || (state_d == S_CHECK);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= 1'b0;
      wait_q     <= '0;
      n_fail_q   <= '0;
      n_vac_q    <= '0;
      cex_x_q    <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cand_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      wait_q     <= wait_d;
      n_fail_q   <= n_fail_d;
      n_vac_q    <= n_vac_d;
      cex_x_q    <= cex_x_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      cand_req_q <= cand_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cand.cand_x   = x_q;
  assign cand.cand_req = cand_req_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign cex_x         = cex_x_q;
  assign n_fail        = n_fail_q;
  assign n_vac         = n_vac_q;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Directed bench: three checker instances (F is y = x[0] with stop / no-stop,
// and F = 0) driven by simple candidate models.
module tb_skolem_sweep_checker;
  localparam logic [127:0] SPEC_X0 = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [2:0] busy_v, done_v, pass_v, to_v;
  logic [5:0] cex_a, cex_b, cex_c;
  logic [6:0] nf_a, nf_b, nf_c, nv_a, nv_b, nv_c;

  // mode_a: 0 immediate ack, 1 random 0-3 cycle delay, 2 never ack
  int   mode_a   = 0;
  logic ywrong_a = 1'b0;
  int   dcnt     = 0;
  int   stab_viol = 0;
  logic       prev_req = 1'b0;
  logic [5:0] prev_x   = '0;

  int checks   = 0;
  int failures = 0;

  skolem_sweep_checker_if if_a ();
  skolem_sweep_checker_if if_b ();
  skolem_sweep_checker_if if_c ();

  skolem_sweep_checker #(.SPEC_TT(SPEC_X0), .TIMEOUT(16), .STOP_ON_FAIL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cand(if_a),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .timeout(to_v[0]),
    .cex_x(cex_a), .n_fail(nf_a), .n_vac(nv_a));

  skolem_sweep_checker #(.SPEC_TT(SPEC_X0), .TIMEOUT(16), .STOP_ON_FAIL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cand(if_b),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .timeout(to_v[1]),
    .cex_x(cex_b), .n_fail(nf_b), .n_vac(nv_b));

  skolem_sweep_checker #(.SPEC_TT(128'h0), .TIMEOUT(16), .STOP_ON_FAIL(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .cand(if_c),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .timeout(to_v[2]),
    .cex_x(cex_c), .n_fail(nf_c), .n_vac(nv_c));

  assign if_a.cand_ack = if_a.cand_req &
                         ((mode_a == 0) ? 1'b1 : (mode_a == 1) ? (dcnt == 0) : 1'b0);
  assign if_a.cand_y   = ywrong_a ? 1'b0 : if_a.cand_x[0];
  assign if_b.cand_ack = if_b.cand_req;
  assign if_b.cand_y   = 1'b0;
  assign if_c.cand_ack = if_c.cand_req;
  assign if_c.cand_y   = if_c.cand_x[1] ^ if_c.cand_x[3];

  always @(negedge clk) begin
    if (!if_a.cand_req) dcnt <= $urandom_range(0, 3);
    else if (dcnt != 0) dcnt <= dcnt - 1;
    if (if_a.cand_req && prev_req && (if_a.cand_x != prev_x)) stab_viol <= stab_viol + 1;
    prev_req <= if_a.cand_req;
    prev_x   <= if_a.cand_x;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start on one instance and counts cycles (start cycle = 0) until done.
  task automatic run_sweep(input int sel, input int limit, output int cyc,
                           output logic d1, output logic r1, output logic [5:0] x1);
    logic dn;
    cyc = 0; d1 = 1'b0; r1 = 1'b0; x1 = '0; dn = 1'b0;
    case (sel)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    while (cyc < limit && !dn) begin
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      cyc++;
      case (sel)
        0: dn = done_v[0];
        1: dn = done_v[1];
        default: dn = done_v[2];
      endcase
      if (cyc == 1) begin
        d1 = dn;
        case (sel)
          0: begin r1 = if_a.cand_req; x1 = if_a.cand_x; end
          1: begin r1 = if_b.cand_req; x1 = if_b.cand_x; end
          default: begin r1 = if_c.cand_req; x1 = if_c.cand_x; end
        endcase
      end
    end
    check("sweep_done_within_bound", dn, 1'b1);
  endtask

  initial begin
    int cyc;
    logic d1, r1, found;
    logic [5:0] x1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_v, 3'b000);
    check("rst_done", done_v, 3'b000);
    check("rst_pass", pass_v, 3'b000);
    check("rst_timeout", to_v, 3'b000);
    check("rst_cand_req", if_a.cand_req, 1'b0);
    check("rst_cand_x", if_a.cand_x, 6'd0);
    check("rst_n_fail", nf_a, 7'd0);
    check("rst_n_vac", nv_a, 7'd0);
    check("rst_cex_x", cex_a, 6'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // correct candidate, immediate ack
    run_sweep(0, 300, cyc, d1, r1, x1);
    check("ok_first_req", r1, 1'b1);
    check("ok_first_x", x1, 6'd0);
    check("ok_latency", cyc, 129);
    check("ok_pass", pass_v[0], 1'b1);
    check("ok_n_fail", nf_a, 7'd0);
    check("ok_n_vac", nv_a, 7'd0);
    check("ok_timeout", to_v[0], 1'b0);
    check("ok_cex", cex_a, 6'd0);
    check("ok_busy_low", busy_v[0], 1'b0);

    // y = 0 candidate, stop at first failure; start issued from DONE
    ywrong_a = 1'b1;
    run_sweep(0, 300, cyc, d1, r1, x1);
    check("stop_done_fell", d1, 1'b0);
    check("stop_latency", cyc, 5);
    check("stop_pass", pass_v[0], 1'b0);
    check("stop_cex", cex_a, 6'd1);
    check("stop_n_fail", nf_a, 7'd1);
    check("stop_n_vac", nv_a, 7'd0);
    ywrong_a = 1'b0;

    // y = 0 candidate, full sweep
    run_sweep(1, 300, cyc, d1, r1, x1);
    check("full_latency", cyc, 129);
    check("full_n_fail", nf_b, 7'd32);
    check("full_cex", cex_b, 6'd1);
    check("full_pass", pass_v[1], 1'b0);
    check("full_timeout", to_v[1], 1'b0);

    // F = 0: every vector vacuous
    run_sweep(2, 300, cyc, d1, r1, x1);
    check("vac_n_vac", nv_c, 7'd64);
    check("vac_n_fail", nf_c, 7'd0);
    check("vac_pass", pass_v[2], 1'b1);

    // no ack: timeout
    mode_a = 2;
    run_sweep(0, 100, cyc, d1, r1, x1);
    check("to_latency", cyc, 17);
    check("to_timeout", to_v[0], 1'b1);
    check("to_pass", pass_v[0], 1'b0);
    check("to_cex", cex_a, 6'd0);
    check("to_n_fail", nf_a, 7'd0);

    // random ack delays, correct candidate
    mode_a = 1;
    run_sweep(0, 700, cyc, d1, r1, x1);
    check("dly_pass", pass_v[0], 1'b1);
    check("dly_timeout", to_v[0], 1'b0);
    check("dly_n_fail", nf_a, 7'd0);
    check("dly_min_latency", (cyc >= 129), 1'b1);
    check("dly_x_stable", stab_viol, 0);

    // reset in the middle of a sweep
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (if_a.cand_x == 6'd30) found = 1'b1;
    end
    check("mid_reached_x30", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_req_async_drop", if_a.cand_req, 1'b0);
    check("mid_busy_async_drop", busy_v[0], 1'b0);
    @(posedge clk); #1;
    check("mid_cand_x", if_a.cand_x, 6'd0);
    check("mid_done", done_v[0], 1'b0);
    check("mid_pass", pass_v[0], 1'b0);
    check("mid_timeout", to_v[0], 1'b0);
    check("mid_n_fail", nf_a, 7'd0);
    check("mid_n_vac", nv_a, 7'd0);
    check("mid_cex", cex_a, 6'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_sweep(0, 700, cyc, d1, r1, x1);
    check("re_first_req", r1, 1'b1);
    check("re_first_x", x1, 6'd0);
    check("re_pass", pass_v[0], 1'b1);
    check("re_n_fail", nf_a, 7'd0);
    check("re_x_stable", stab_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
